// File: rtl/delay_pulse_gen_pkg.sv
// Shared definitions for the delay-pulse launch path and related timing blocks.
package delay_pulse_gen_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        PULSE = 2'd2
    } state_t;

    localparam int DW_DEFAULT      = 8;
    localparam int PULSE_W_DEFAULT = 4;

    // Width of a counter that must hold values 0..pulse_w
    function automatic int width_cnt_bits(input int pulse_w);
        return $clog2(pulse_w + 1);
    endfunction

endpackage

// File: rtl/delay_pulse_gen_down_counter.sv
// Loadable saturating down-counter with zero flag; reusable by other timing blocks.
module delay_down_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] value,
    output logic         zero
);

    // Load has priority; decrement stops at zero so the counter never wraps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (dec && (value != '0)) begin
            value <= value - W'(1);
        end
    end

    // Zero flag decoded from the registered count
    always_comb begin
        zero = (value == '0);
    end

endmodule

// File: rtl/delay_pulse_gen.sv
// Programmable delay-pulse generator: counts a sampled delay down, then emits a
// fixed-width pulse; optionally re-launches with the held delay.
// The repeat input is named repeat_en because "repeat" is a reserved word.
module delay_pulse_gen
    import delay_pulse_gen_pkg::*;
#(
    parameter int DW      = DW_DEFAULT,
    parameter int PULSE_W = PULSE_W_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ena,
    input  logic          start,
    input  logic          repeat_en,
    input  logic [DW-1:0] delay,
    output logic          pulse_out,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] cycles
);

    localparam int WW = width_cnt_bits(PULSE_W);

    state_t        state;
    logic [DW-1:0] delay_q;
    logic [WW-1:0] width_cnt;

    logic          cnt_load;
    logic [DW-1:0] cnt_load_val;
    logic          cnt_dec;
    logic          cnt_zero;

    // Counter control: load on accept/relaunch, clear on abort, count down in DELAY
    always_comb begin
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        if (!ena) begin
            cnt_load     = 1'b1;
            cnt_load_val = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt_load     = 1'b1;
                        cnt_load_val = delay;
                    end
                end
                DELAY: begin
                    cnt_dec = !cnt_zero;
                end
                PULSE: begin
                    if ((width_cnt == '0) && repeat_en) begin
                        cnt_load     = 1'b1;
                        cnt_load_val = delay_q;
                    end
                end
                default: begin
                    cnt_dec = 1'b0;
                end
            endcase
        end
    end

    delay_down_counter #(
        .W(DW)
    ) u_down_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .value    (cycles),
        .zero     (cnt_zero)
    );

    // Control FSM with registered pulse/busy/done and pulse-width counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pulse_out <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            delay_q   <= '0;
            width_cnt <= '0;
        end else begin
            done <= 1'b0;
            if (!ena) begin
                state     <= IDLE;
                pulse_out <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state   <= DELAY;
                            delay_q <= delay;
                            busy    <= 1'b1;
                        end
                    end
                    DELAY: begin
                        if (cnt_zero) begin
                            state     <= PULSE;
                            pulse_out <= 1'b1;
                            width_cnt <= WW'(PULSE_W - 1);
                        end
                    end
                    PULSE: begin
                        if (width_cnt == '0) begin
                            pulse_out <= 1'b0;
                            done      <= 1'b1;
                            if (repeat_en) begin
                                state <= DELAY;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            width_cnt <= width_cnt - WW'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
